// File: rtl/median_prep_pkg.sv
// Shared definitions for the median-preparation pipeline.
//   WIN_DIM   : side length of the square neighbourhood
//   WIN_ELEMS : number of pixels in one window
//   win_idx   : flat element index of window position (r, c); r=0 top, c=0 left
package median_prep_pkg;

  localparam int WIN_DIM   = 3;
  localparam int WIN_ELEMS = WIN_DIM * WIN_DIM;

  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/window_3x3_assembler_raster_counter.sv
// Raster position tracker: counts accepted pixels across a frame.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   advance  : one pixel accepted this cycle
//   col, row : position of the pixel currently presented (before advance)
//   last     : current position is the final pixel of the frame
module raster_counter #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(IMG_W - 1));
  assign row_end = (row == ROW_W'(IMG_H - 1));
  assign last    = col_end && row_end;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        // Last pixel of the frame wraps both counters, so the next frame
        // starts immediately with no idle cycle.
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_3x3_assembler.sv
// 3x3 neighbourhood builder feeding the median sorter.
// Takes the live pixel plus two line-buffer taps on one strobe and emits one
// window per interior centre pixel (no border padding).
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   done_i        : pixel strobe; all three data inputs valid this cycle
//   data_row0_i   : newest line (bottom of window)
//   data_row1_i   : tap one line old (middle)
//   data_row2_i   : tap two lines old (top)
//   window_o      : element k = 3*r + c at [k*WIDTH +: WIDTH], r=0 top, c=0 left
//   done_o        : window_o valid strobe, one cycle per window
//   frame_done_o  : one-cycle pulse with the last window of a frame
module window_3x3_assembler
  import median_prep_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic [WIDTH-1:0]           data_row0_i,
  input  logic [WIDTH-1:0]           data_row1_i,
  input  logic [WIDTH-1:0]           data_row2_i,
  output logic [WIN_ELEMS*WIDTH-1:0] window_o,
  output logic                       done_o,
  output logic                       frame_done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             last_px;
  logic             interior;

  // Column storage indexed [row], row 0 = top. The live taps act as the
  // right-hand column, so only the two older columns need registers.
  logic [WIDTH-1:0] left_col [WIN_DIM];
  logic [WIDTH-1:0] mid_col  [WIN_DIM];
  logic [WIDTH-1:0] live_col [WIN_DIM];

  logic [WIN_ELEMS*WIDTH-1:0] win_next;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .advance (done_i),
    .col     (col_cnt),
    .row     (row_cnt),
    .last    (last_px)
  );

  // A window exists only once two full rows and two columns of the current
  // line precede the pixel; this also keeps last line's stale columns out.
  assign interior = (row_cnt >= ROW_W'(2)) && (col_cnt >= COL_W'(2));

  assign live_col[0] = data_row2_i;
  assign live_col[1] = data_row1_i;
  assign live_col[2] = data_row0_i;

  // NOTE: the combinational result gets a full default before the loops so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_next = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      win_next[win_idx(r, 0)*WIDTH +: WIDTH] = left_col[r];
      win_next[win_idx(r, 1)*WIDTH +: WIDTH] = mid_col[r];
      win_next[win_idx(r, 2)*WIDTH +: WIDTH] = live_col[r];
    end
  end

  // NOTE: the column registers are small register arrays, not RAM, so they
  // are cleared on reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        left_col[r] <= '0;
        mid_col[r]  <= '0;
      end
    end else if (done_i) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        left_col[r] <= mid_col[r];
        mid_col[r]  <= live_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_o     <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= done_i && interior;
      frame_done_o <= done_i && last_px;
      // window_o holds its last value between windows.
      if (done_i && interior) begin
        window_o <= win_next;
      end
    end
  end

endmodule
